keycode_fifo_pio: RTL and testbench
===================================

Name: keycode_fifo_pio

Overview:
Parametrised Avalon-MM slave, successor to the single-register keycode PIO. The Nios II USB-keyboard driver writes keycodes into a FIFO. Hardware consumers (game/sprite logic) drain the FIFO through a valid/ready stream. A "held keycode" register stays available as a level output for legacy consumers. Adds status, flush, overflow detection and a threshold/overflow interrupt.

Parameters:
DATA_W, 16, keycode width (1..32)
DEPTH, 8, FIFO entries; power of two, >= 2
IRQ_THRESH, 1, FIFO level at or above which the level interrupt asserts (1..DEPTH)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  active-low write strobe
read_n  in  1  active-low read strobe (needed for pop-on-read side effects: none; kept for fabric)
writedata  in  32  write data
readdata  out  32  read data, zero-extended, combinational (read latency 0)
irq  out  1  interrupt request, level
out_port  out  DATA_W  last keycode written (held register)
key_data  out  DATA_W  FIFO head
key_valid  out  1  FIFO non-empty
key_ready  in  1  consumer accepts head

Behaviour:
- Register map (wr = chipselect & ~write_n):
  - 0 KEY: wr -> out_port <= writedata[DATA_W-1:0]; push into FIFO if CTRL.en. Read returns out_port.
  - 1 STATUS: read {.., level[LW-1:0] at bits [LW+7:8], irq_pend bit3, ovf bit2, full bit1, empty bit0}, with LW = clog2(DEPTH)+1. Write 1 to bit2 clears ovf.
  - 2 CTRL: bit0 en (reset 1), bit1 flush (write-1, self-clearing, reads 0), bit2 irq_en (reset 0).
  - 3 reserved: reads 0, writes ignored.
- Reset values: out_port 0, FIFO empty (level 0, pointers 0), ovf 0, en 1, irq_en 0, irq 0, key_valid 0. key_data is don't-care while key_valid=0 (bench must not check it).
- FIFO: show-ahead. key_data = mem[rd_ptr]; key_valid = (level != 0).
  - Pop when key_valid & key_ready.
  - Push when KEY write & en.
  - Pointers wrap modulo DEPTH; level is a separate counter, 0..DEPTH.
- Push/pop interaction, single cycle:
  - Push with level<DEPTH: entry stored, level+1 (net 0 if simultaneous pop).
  - Push at level==DEPTH with simultaneous pop: accepted, level stays DEPTH.
  - Push at level==DEPTH without pop: data dropped, ovf <= 1 (sticky); out_port still updates.
  - Pop at level 0: impossible, since key_valid=0.
- Flush: pointers and level cleared next cycle. Flush beats a same-cycle push or pop; the pushed data is discarded but out_port still updates. ovf is unaffected.
- Push with en=0: no FIFO change, no ovf; out_port updates.
- ovf clear and overflow event in the same cycle: set wins.
- irq_pend = ovf | (level >= IRQ_THRESH). irq = irq_en & irq_pend, registered, so it asserts one cycle after the causing state.
- All state updates on posedge clk. readdata reflects pre-edge state.
- reset_n asserted mid-operation: immediate asynchronous return to the reset values. FIFO contents are lost.

Decomposition:
- Package keycode_pio_pkg:
  - address constants (ADDR_KEY=0, ADDR_STATUS=1, ADDR_CTRL=2)
  - STATUS/CTRL bit-index constants
  - helper for level width
- One sub-module, keycode_sync_fifo: mem, pointers, level, full/empty, flush input, push/pop.
- Avalon decode, CTRL/STATUS, held register and irq stay in the top.

Test Plan:
- Reset, then read all addresses -> KEY=0, STATUS=0x00000001 (empty), CTRL=0x00000001, irq=0, key_valid=0.
- Write KEY 0x001A, 0x0016, 0x0004 with key_ready=0 -> out_port=0x0004, level=3, key_data=0x001A. Raise key_ready -> 0x001A, 0x0016, 0x0004 on consecutive cycles, then key_valid=0.
- DEPTH=8: write 9 keys 0x01..0x09, ready=0 -> STATUS full=1, ovf=1, level=8, out_port=0x09. Drain yields 0x01..0x08. Write STATUS 0x4 -> ovf=0.
- Full FIFO, push 0x2C with simultaneous pop -> no ovf, level stays 8, 0x2C is the last entry drained.
- CTRL irq_en=1, IRQ_THRESH=1: first KEY write -> irq high one cycle later. Flush (CTRL=0x7) -> level=0, irq low next cycle. Same-cycle push+flush leaves FIFO empty.
- Assert reset_n low for 1 cycle mid-stream with level=5 -> immediately level=0, key_valid=0, out_port=0, CTRL back to 0x1.

Source files
------------

// File: rtl/keycode_pio_pkg.sv
// rtl/keycode_pio_pkg.sv - shared constants for the keycode FIFO PIO
// Contents: register addresses, STATUS/CTRL bit positions, level-width helper.
package keycode_pio_pkg;

  localparam logic [1:0] ADDR_KEY    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  // STATUS bit positions; the level field starts at ST_LEVEL_LSB
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_IRQ_PEND  = 3;
  localparam int ST_LEVEL_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // Level counts 0..depth inclusive, so it needs one bit more than a pointer
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/keycode_sync_fifo.sv
// rtl/keycode_sync_fifo.sv - show-ahead synchronous FIFO with flush
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   flush_i           clear pointers and level (wins over push/pop)
//   push_i, push_data_i   write request and data
//   pop_i             consumer accepted head
//   head_o            entry at read pointer (valid while !empty_o)
//   level_o           entries held, 0..DEPTH
//   full_o, empty_o   level == DEPTH / level == 0
//   overflow_o        push dropped because FIFO full with no pop
module keycode_sync_fifo
  import keycode_pio_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_i,
  output logic [DATA_W-1:0]       head_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              accept;
  logic              pop_ok;

  assign full_o  = (level_q == DEPTH_L);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves this cycle
  assign accept     = push_i & (~full_o | pop_i);
  assign pop_ok     = pop_i & ~empty_o;
  assign overflow_o = push_i & full_o & ~pop_i & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow
      wr_ptr_d = wr_ptr_q + AW'(accept);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      level_d  = level_q + LW'(accept) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only visible once level covers it
  always_ff @(posedge clk) begin
    if (accept && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/keycode_fifo_pio.sv
// rtl/keycode_fifo_pio.sv - Avalon-MM keycode PIO with FIFO, status and irq
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   address, chipselect, write_n, read_n Avalon-MM slave controls
//   writedata, readdata                  Avalon data (readdata combinational)
//   irq                                  registered level interrupt
//   out_port                             last keycode written (held)
//   key_data, key_valid, key_ready       FIFO head stream to consumers
module keycode_fifo_pio
  import keycode_pio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int IRQ_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] key_data,
  output logic              key_valid,
  input  logic              key_ready
);

  localparam int LW = level_w(DEPTH);

  logic              wr, wr_key, wr_status, wr_ctrl;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic              en_q, en_d;
  logic              irq_en_q, irq_en_d;
  logic              ovf_q, ovf_d;
  logic              irq_q, irq_d;
  logic              irq_pend;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic [LW-1:0]     fifo_level;
  logic              fifo_full, fifo_empty, fifo_overflow;

  // Reads have no side effects, so read_n and the unused writedata bits are only held for the fabric
  logic              unused_bits;
  assign unused_bits = &{1'b0, read_n, writedata};

  assign wr        = chipselect & ~write_n;
  assign wr_key    = wr & (address == ADDR_KEY);
  assign wr_status = wr & (address == ADDR_STATUS);
  assign wr_ctrl   = wr & (address == ADDR_CTRL);

  assign fifo_push  = wr_key & en_q;
  assign fifo_pop   = key_valid & key_ready;
  assign fifo_flush = wr_ctrl & writedata[CTRL_FLUSH];

  keycode_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i (writedata[DATA_W-1:0]),
    .pop_i       (fifo_pop),
    .head_o      (key_data),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .overflow_o  (fifo_overflow)
  );

  assign key_valid = ~fifo_empty;
  assign irq_pend  = ovf_q | (fifo_level >= LW'(IRQ_THRESH));

  always_comb begin
    out_port_d = out_port_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q;
    if (wr_key) begin
      out_port_d = writedata[DATA_W-1:0];
    end
    if (wr_ctrl) begin
      en_d     = writedata[CTRL_EN];
      irq_en_d = writedata[CTRL_IRQ_EN];
    end
    // A new overflow beats a same-cycle clear so no event is lost
    if (fifo_overflow) begin
      ovf_d = 1'b1;
    end else if (wr_status && writedata[ST_OVF]) begin
      ovf_d = 1'b0;
    end
    irq_d = irq_en_q & irq_pend;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port_q <= '0;
      en_q       <= 1'b1;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_port_q <= out_port_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
    end
  end

  assign out_port = out_port_q;
  assign irq      = irq_q;

  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_KEY:    readdata = 32'(out_port_q);
      ADDR_STATUS: readdata = {{(32-ST_LEVEL_LSB-LW){1'b0}}, fifo_level, 4'b0000,
                               irq_pend, ovf_q, fifo_full, fifo_empty};
      ADDR_CTRL:   readdata = {29'h0, irq_en_q, 1'b0, en_q};
      default:     readdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_keycode_fifo_pio.sv
// tb/tb_keycode_fifo_pio.sv - scoreboard bench for keycode_fifo_pio
module tb_keycode_fifo_pio;

  localparam int DEPTH  = 8;
  localparam int THRESH = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        irq;
  logic [15:0] out_port;
  logic [15:0] key_data;
  logic        key_valid;
  logic        key_ready = 1'b0;

  keycode_fifo_pio #(.DATA_W(16), .DEPTH(DEPTH), .IRQ_THRESH(THRESH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port),
    .key_data   (key_data),
    .key_valid  (key_valid),
    .key_ready  (key_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_level  = 0;
  bit          m_ovf    = 0;
  bit          m_en     = 1;
  bit          m_irq_en = 0;
  bit          m_irq    = 0;
  logic [15:0] m_out    = 16'h0;
  logic [15:0] exp_q[$];
  logic [31:0] rd_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    int pend;
    pend = (m_ovf || m_level >= THRESH) ? 1 : 0;
    case (a)
      2'd0: return {16'h0, m_out};
      2'd1: return 32'(m_level * 256 + pend * 8 + int'(m_ovf) * 4
                       + ((m_level == DEPTH) ? 2 : 0) + ((m_level == 0) ? 1 : 0));
      2'd2: return 32'(int'(m_en) + int'(m_irq_en) * 4);
      default: return 32'h0;
    endcase
  endfunction

  // Applies one clock edge's worth of bus/consumer activity to the model
  task automatic model_step(input bit wr, input logic [1:0] a, input logic [31:0] d, input bit rdy);
    bit pop, push;
    m_irq = m_irq_en && (m_ovf || m_level >= THRESH);
    pop  = rdy && (m_level > 0);
    push = wr && (a == 2'd0) && m_en;
    if (wr && a == 2'd0) m_out = d[15:0];
    if (wr && a == 2'd2 && d[1]) begin
      m_level = 0;
      exp_q.delete();
    end else begin
      if (push && m_level == DEPTH && !pop) begin
        m_ovf = 1;
      end else begin
        if (wr && a == 2'd1 && d[2]) m_ovf = 0;
        if (push) begin
          exp_q.push_back(d[15:0]);
          m_level++;
        end
      end
      if (pop) m_level--;
    end
    if (wr && a == 2'd2 && d[1] && d[2] == 1'b0 && 1'b0) m_ovf = m_ovf;
    if (wr && a == 2'd1 && d[2] && (wr && a == 2'd2)) m_ovf = 0;
    if (wr && a == 2'd2) begin
      m_en     = d[0];
      m_irq_en = d[2];
    end
  endtask

  task automatic reset_model();
    m_level = 0; m_ovf = 0; m_en = 1; m_irq_en = 0; m_irq = 0; m_out = 16'h0;
    exp_q.delete();
  endtask

  // One bus cycle; rdv returns readdata sampled at the falling edge
  task automatic cycle(input bit wr, input bit rd, input logic [1:0] a, input logic [31:0] d,
                       input bit rdy, output logic [31:0] rdv);
    chipselect = wr | rd;
    write_n    = ~wr;
    read_n     = ~rd;
    address    = a;
    writedata  = d;
    key_ready  = rdy;
    if (rd) rd_q.push_back(exp_read(a));
    @(negedge clk);
    rdv = readdata;
    @(posedge clk);
    model_step(wr, a, d, rdy);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
  endtask

  // Monitor: compares every observable output against the model each cycle
  always @(negedge clk) begin
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
    chk("out_port", {16'h0, out_port}, {16'h0, m_out});
    chk("key_valid", {31'h0, key_valid}, {31'h0, (m_level != 0)});
    if (key_valid && key_ready) begin
      if (exp_q.size() == 0) chk("pop_without_expected", 32'h1, 32'h0);
      else chk("key_data", {16'h0, key_data}, {16'h0, exp_q.pop_front()});
    end
    if (chipselect && !read_n) begin
      if (rd_q.size() == 0) chk("read_without_expected", 32'h1, 32'h0);
      else chk("readdata", readdata, rd_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          r;
    bit          rdy;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    cycle(0, 1, 2'd0, 0, 0, v); chk("rst_key", v, 32'h0);
    cycle(0, 1, 2'd1, 0, 0, v); chk("rst_status", v, 32'h1);
    cycle(0, 1, 2'd2, 0, 0, v); chk("rst_ctrl", v, 32'h1);
    cycle(0, 1, 2'd3, 0, 0, v); chk("rst_reserved", v, 32'h0);

    // Three keys held, then drained in order
    cycle(1, 0, 2'd0, 32'h001A, 0, v);
    cycle(1, 0, 2'd0, 32'h0016, 0, v);
    cycle(1, 0, 2'd0, 32'h0004, 0, v);
    chk("three_out_port", {16'h0, out_port}, 32'h0004);
    chk("three_head", {16'h0, key_data}, 32'h001A);
    cycle(0, 1, 2'd1, 0, 0, v); chk("three_status", v, 32'h308);
    repeat (4) cycle(0, 0, 2'd0, 0, 1, v);

    // Overflow: nine keys into eight entries
    for (int i = 1; i <= 9; i++) cycle(1, 0, 2'd0, 32'(i), 0, v);
    chk("ovf_out_port", {16'h0, out_port}, 32'h0009);
    cycle(0, 1, 2'd1, 0, 0, v); chk("ovf_status", v, 32'h80E);
    repeat (8) cycle(0, 0, 2'd0, 0, 1, v);
    cycle(0, 1, 2'd1, 0, 0, v); chk("ovf_drained_status", v, 32'hD);
    cycle(1, 0, 2'd1, 32'h4, 0, v);
    cycle(0, 1, 2'd1, 0, 0, v); chk("ovf_cleared_status", v, 32'h1);

    // Push into a full FIFO while the head leaves
    for (int i = 0; i < 8; i++) cycle(1, 0, 2'd0, 32'h40 + 32'(i), 0, v);
    cycle(1, 0, 2'd0, 32'h2C, 1, v);
    cycle(0, 1, 2'd1, 0, 0, v); chk("full_pushpop_status", v, 32'h80A);
    repeat (9) cycle(0, 0, 2'd0, 0, 1, v);

    // Interrupt timing and flush
    cycle(1, 0, 2'd2, 32'h5, 0, v);
    cycle(1, 0, 2'd0, 32'h33, 0, v);
    chk("irq_not_yet", {31'h0, irq}, 32'h0);
    cycle(0, 0, 2'd0, 0, 0, v);
    chk("irq_raised", {31'h0, irq}, 32'h1);
    cycle(1, 0, 2'd2, 32'h7, 1, v);
    cycle(0, 0, 2'd0, 0, 0, v);
    chk("irq_after_flush", {31'h0, irq}, 32'h0);
    cycle(0, 1, 2'd1, 0, 0, v); chk("flush_status", v, 32'h1);
    cycle(0, 1, 2'd2, 0, 0, v); chk("flush_ctrl_reads", v, 32'h5);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      r   = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 99) < 35);
      if (r < 50)      cycle(1, 0, 2'd0, $urandom, rdy, v);
      else if (r < 62) cycle(0, 1, 2'($urandom_range(0, 3)), 0, rdy, v);
      else if (r < 68) cycle(1, 0, 2'd1, $urandom, rdy, v);
      else if (r < 73) cycle(1, 0, 2'd2, {29'h0, 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) != 0)}, rdy, v);
      else if (r < 76) cycle(1, 0, 2'd3, $urandom, rdy, v);
      else             cycle(0, 0, 2'd0, 0, rdy, v);
    end

    // Asynchronous reset with five entries held
    cycle(1, 0, 2'd2, 32'h3, 0, v);
    for (int i = 0; i < 5; i++) cycle(1, 0, 2'd0, 32'h50 + 32'(i), 0, v);
    chipselect = 1'b1; read_n = 1'b0; address = 2'd1;
    #2 reset_n = 1'b0;
    reset_model();
    #1;
    chk("async_rst_status", readdata, 32'h1);
    chk("async_rst_valid", {31'h0, key_valid}, 32'h0);
    chk("async_rst_out_port", {16'h0, out_port}, 32'h0);
    chipselect = 1'b0; read_n = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle(0, 1, 2'd2, 0, 0, v); chk("async_rst_ctrl", v, 32'h1);
    cycle(0, 1, 2'd1, 0, 0, v); chk("async_rst_status2", v, 32'h1);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
